// File: rtl/cnnip_kernel_sched.sv
`default_nettype none
// =============================================================================
// cnnip_kernel_sched : runs MODE_KERNEL_NUMS back-to-back conv passes per layer
// start, with a per-pass watchdog. Optional macro CNNIP_SCHED_PERF_EN enables
// the PERF_CYCLES layer cycle counter.
// Revision: 1.0
// =============================================================================
module cnnip_kernel_sched #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_a,
  input  logic              arstz_aq,
  input  logic              CMD_START,
  input  logic              CMD_ABORT,
  input  logic [7:0]        MODE_KERNEL_NUMS,
  input  logic [7:0]        MODE_KERNEL_SIZE,
  input  logic [ADDR_W-1:0] CFG_FMAP_WORDS,
  output logic              sub_start,
  output logic [ADDR_W-1:0] sub_wbase,
  output logic [ADDR_W-1:0] sub_fbase,
  input  logic              sub_done,
  output logic [7:0]        kernel_idx,
  output logic              busy,
  output logic              CMD_DONE,
  output logic              CMD_DONE_VALID,
  output logic              err_timeout,
  output logic [31:0]       PERF_CYCLES
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYC);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FIN    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic [7:0]          nums;
  logic [ADDR_W-1:0]   wstep, fstep;
  logic [WDOG_W-1:0]   wdog;
  logic [15:0]         ksq;
  logic                start_ok, last_pass, wdog_hit;

  assign ksq       = 16'(MODE_KERNEL_SIZE) * 16'(MODE_KERNEL_SIZE);
  assign start_ok  = (state == S_IDLE) && CMD_START;
  assign last_pass = (kernel_idx == nums - 8'd1);
  assign wdog_hit  = (wdog == WDOG_LAST);

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (CMD_START) state_nx = (MODE_KERNEL_NUMS == 8'd0) ? S_FIN : S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (sub_done) state_nx = S_NEXT;
                else if (wdog_hit) state_nx = S_ERR;
      S_NEXT:   state_nx = last_pass ? S_FIN : S_LAUNCH;
      S_FIN:    state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    // Abort overrides every other transition, and suppresses this cycle's strobes.
    if (CMD_ABORT && (state != S_IDLE)) state_nx = S_IDLE;
  end

  assign busy           = (state != S_IDLE);
  assign sub_start      = (state == S_LAUNCH) && !CMD_ABORT;
  assign CMD_DONE       = (state == S_FIN) && !CMD_ABORT;
  assign CMD_DONE_VALID = ((state == S_FIN) || (state == S_ERR)) && !CMD_ABORT;

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      nums        <= '0;
      wstep       <= '0;
      fstep       <= '0;
      sub_wbase   <= '0;
      sub_fbase   <= '0;
      kernel_idx  <= '0;
      err_timeout <= 1'b0;
      wdog        <= '0;
    end else begin
      wdog <= (state == S_WAIT) ? wdog + 1'b1 : '0;
      if (start_ok) begin
        nums        <= MODE_KERNEL_NUMS;
        wstep       <= ADDR_W'({ksq, 2'b00});
        fstep       <= ADDR_W'({CFG_FMAP_WORDS, 2'b00});
        sub_wbase   <= '0;
        sub_fbase   <= '0;
        kernel_idx  <= '0;
        err_timeout <= 1'b0;
      end
      if ((state == S_NEXT) && !CMD_ABORT && !last_pass) begin
        kernel_idx <= kernel_idx + 8'd1;
        sub_wbase  <= sub_wbase + wstep;
        sub_fbase  <= sub_fbase + fstep;
      end
      if ((state == S_ERR) && !CMD_ABORT) err_timeout <= 1'b1;
    end
  end

`ifdef CNNIP_SCHED_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      perf_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (CMD_START) perf_cnt <= '0;
    end else if (perf_cnt != 32'hFFFF_FFFF) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign PERF_CYCLES = perf_cnt;
`else
  assign PERF_CYCLES = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnnip_kernel_sched.sv
`default_nettype none
// =============================================================================
// tb_cnnip_kernel_sched : randomized scoreboard bench for cnnip_kernel_sched.
// Revision: 1.0
// =============================================================================
module tb_cnnip_kernel_sched;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;
  localparam int AMOD    = 1 << ADDR_W;

  logic              clk_a = 1'b0;
  logic              arstz_aq;
  logic              CMD_START, CMD_ABORT, sub_done;
  logic [7:0]        MODE_KERNEL_NUMS, MODE_KERNEL_SIZE;
  logic [ADDR_W-1:0] CFG_FMAP_WORDS;
  logic              sub_start, busy, CMD_DONE, CMD_DONE_VALID, err_timeout;
  logic [ADDR_W-1:0] sub_wbase, sub_fbase;
  logic [7:0]        kernel_idx;
  logic [31:0]       PERF_CYCLES;

  cnnip_kernel_sched #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq),
    .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
    .MODE_KERNEL_NUMS(MODE_KERNEL_NUMS), .MODE_KERNEL_SIZE(MODE_KERNEL_SIZE),
    .CFG_FMAP_WORDS(CFG_FMAP_WORDS),
    .sub_start(sub_start), .sub_wbase(sub_wbase), .sub_fbase(sub_fbase),
    .sub_done(sub_done), .kernel_idx(kernel_idx), .busy(busy),
    .CMD_DONE(CMD_DONE), .CMD_DONE_VALID(CMD_DONE_VALID),
    .err_timeout(err_timeout), .PERF_CYCLES(PERF_CYCLES)
  );

  always #5 clk_a = ~clk_a;

  typedef struct {
    bit is_done;
    int kidx;
    int wb;
    int fb;
    bit done;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_total = 0;
  int  n_pass  = 0;
  int  busy_cnt = 0;
  int  fixed_d = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic flag_fail(input string nm);
    n_total++;
    $display("FAIL %s: expected event did not occur", nm);
  endtask

  task automatic cyc();
    @(posedge clk_a);
    #1;
  endtask

  task automatic apply_reset();
    arstz_aq = 1'b0;
    repeat (2) cyc();
    @(negedge clk_a);
    arstz_aq = 1'b1;
    cyc();
  endtask

  // Monitor: every sub_start / completion strobe consumes one expected event.
  always @(negedge clk_a) begin
    if (arstz_aq) begin
      if (busy) busy_cnt++;
      if (sub_start) begin
        if (exp_q.size() == 0) flag_fail("unexpected_sub_start_absent");
        else begin
          mon_e = exp_q.pop_front();
          check("ev_kind_launch", 0, mon_e.is_done);
          if (!mon_e.is_done) begin
            check("kernel_idx", kernel_idx, mon_e.kidx);
            check("sub_wbase", sub_wbase, mon_e.wb);
            check("sub_fbase", sub_fbase, mon_e.fb);
          end
        end
      end
      if (CMD_DONE_VALID) begin
        if (exp_q.size() == 0) flag_fail("unexpected_done_absent");
        else begin
          mon_e = exp_q.pop_front();
          check("ev_kind_done", 1, mon_e.is_done);
          if (mon_e.is_done) check("cmd_done", CMD_DONE, mon_e.done);
        end
      end
    end
  end

  // Reference: pass i uses base i*step mod 2^ADDR_W; non-IDLE cycles are
  // 1 (launch) + d (wait) + 1 (next) per pass plus one FIN/ERR cycle.
  task automatic run_layer(input int nums, input int k, input int fmap,
                           input int to_pass, input int ab_pass);
    int  n_launch, d, exp_cyc, base, exp_perf;
    bit  seen;
    ev_t e;
    if (to_pass >= nums) to_pass = -1;
    if (ab_pass >= nums) ab_pass = -1;
    n_launch = nums;
    if (to_pass >= 0) n_launch = to_pass + 1;
    if (ab_pass >= 0) n_launch = ab_pass + 1;
    for (int i = 0; i < n_launch; i++) begin
      e.is_done = 0; e.kidx = i; e.done = 0;
      e.wb = (i * k * k * 4) % AMOD;
      e.fb = (i * fmap * 4) % AMOD;
      exp_q.push_back(e);
    end
    if (ab_pass < 0) begin
      e.is_done = 1; e.kidx = 0; e.wb = 0; e.fb = 0; e.done = (to_pass < 0);
      exp_q.push_back(e);
    end

    MODE_KERNEL_NUMS = 8'(nums);
    MODE_KERNEL_SIZE = 8'(k);
    CFG_FMAP_WORDS   = ADDR_W'(fmap);
    CMD_START = 1'b1;
    cyc();
    CMD_START = 1'b0;
    base = busy_cnt;
    check("err_clear_on_start", err_timeout, 0);
    MODE_KERNEL_NUMS = 8'($urandom);
    MODE_KERNEL_SIZE = 8'($urandom);
    CFG_FMAP_WORDS   = ADDR_W'($urandom);

    exp_cyc = (nums == 0) ? 1 : 0;
    for (int i = 0; i < n_launch; i++) begin
      seen = 0;
      for (int w = 0; w < 6 && !seen; w++) begin
        if (sub_start) seen = 1;
        else cyc();
      end
      if (!seen) begin
        flag_fail("launch_wait");
        apply_reset();
        exp_q.delete();
        return;
      end
      if (i == to_pass) begin
        exp_cyc += TIMEOUT + 2;
        break;
      end
      d = (fixed_d > 0) ? fixed_d : $urandom_range(1, TIMEOUT);
      for (int j = 0; j < d; j++) begin
        if (j == 0 && $urandom_range(0, 1) == 1) begin
          CMD_START = 1'b1;
          MODE_KERNEL_NUMS = 8'($urandom_range(0, 3));
        end
        cyc();
        CMD_START = 1'b0;
      end
      sub_done  = 1'b1;
      CMD_ABORT = (i == ab_pass);
      cyc();
      sub_done  = 1'b0;
      CMD_ABORT = 1'b0;
      if (i == ab_pass) begin
        exp_cyc += 1 + d;
        check("abort_idle_next", busy, 0);
      end else begin
        exp_cyc += d + 2;
      end
    end
    if (ab_pass < 0 && to_pass < 0 && nums > 0) exp_cyc += 1;

    for (int w = 0; w < TIMEOUT + 20 && busy; w++) cyc();
    if (busy) begin
      flag_fail("layer_end");
      apply_reset();
      exp_q.delete();
      return;
    end
    cyc();
`ifdef CNNIP_SCHED_PERF_EN
    exp_perf = exp_cyc;
`else
    exp_perf = 0;
`endif
    check("busy_cycles", busy_cnt - base, exp_cyc);
    check("perf_cycles", PERF_CYCLES, exp_perf);
    check("err_timeout", err_timeout, (to_pass >= 0) ? 1 : 0);
    check("events_consumed", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ev_t e;
    arstz_aq = 1'b0;
    CMD_START = 1'b0; CMD_ABORT = 1'b0; sub_done = 1'b0;
    MODE_KERNEL_NUMS = 8'd0; MODE_KERNEL_SIZE = 8'd0; CFG_FMAP_WORDS = '0;
    repeat (3) cyc();
    @(negedge clk_a);
    arstz_aq = 1'b1;
    cyc();
    check("rst_sub_start", sub_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done_valid", CMD_DONE_VALID, 0);
    check("rst_done", CMD_DONE, 0);
    check("rst_err", err_timeout, 0);
    check("rst_kidx", kernel_idx, 0);
    check("rst_wbase", sub_wbase, 0);
    check("rst_fbase", sub_fbase, 0);
    check("rst_perf", PERF_CYCLES, 0);

    fixed_d = 10;      run_layer(3, 5, 16, -1, -1);
    fixed_d = 0;       run_layer(0, 7, 9, -1, -1);
                       run_layer(2, 3, 4, 1, -1);
    check("err_sticky_idle", err_timeout, 1);
                       run_layer(2, 16, 200, -1, -1);
    fixed_d = TIMEOUT; run_layer(2, 2, 3, -1, -1);
    fixed_d = 0;       run_layer(3, 4, 8, -1, 1);
    check("abort_err_unchanged", err_timeout, 0);
                       run_layer(1, 3, 2, 0, -1);

    for (int n = 0; n < 8; n++) begin
      run_layer($urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, AMOD - 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, -1);
    end

    // Async reset while pass 1 is in WAIT.
    for (int i = 0; i < 2; i++) begin
      e.is_done = 0; e.kidx = i; e.wb = i * 36; e.fb = i * 20; e.done = 0;
      exp_q.push_back(e);
    end
    MODE_KERNEL_NUMS = 8'd3; MODE_KERNEL_SIZE = 8'd3; CFG_FMAP_WORDS = ADDR_W'(5);
    CMD_START = 1'b1;
    cyc();
    CMD_START = 1'b0;
    repeat (2) cyc();
    sub_done = 1'b1;
    cyc();
    sub_done = 1'b0;
    repeat (3) cyc();
    #2 arstz_aq = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_kidx", kernel_idx, 0);
    check("arst_wbase", sub_wbase, 0);
    check("arst_fbase", sub_fbase, 0);
    check("arst_perf", PERF_CYCLES, 0);
    sub_done = 1'b1;
    cyc();
    sub_done = 1'b0;
    @(negedge clk_a);
    arstz_aq = 1'b1;
    repeat (10) cyc();
    check("arst_stays_idle", busy, 0);
    check("arst_events_consumed", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
